// File: rtl/scarv_cop_lsu.sv
// scarv_cop_lsu -- load/store unit of the crypto co-processor.
//
// Executes byte, halfword and word accesses, plus multi-beat scatter/gather
// accesses (byte: 4 beats, half: 2 beats), on the COP memory port. Results are
// returned over a valid/ack handshake. All request fields are latched when the
// request is accepted; every memory-side output and the response are registered.
//
// Ports:
//   g_clk, g_reset         clock, synchronous active-high reset
//   lsu_req / lsu_req_ack  request valid / accepted this cycle (req && idle)
//   lsu_store, lsu_size    direction, access size (0 byte, 1 half, 2 word)
//   lsu_sg, lsu_offsets    scatter/gather enable and per-beat offsets
//   lsu_addr, lsu_wdata    base byte address, store data
//   lsu_abort              abort the in-flight operation
//   lsu_rsp_valid/_ack     response handshake
//   lsu_rdata, lsu_result  load data, status (0 ok, 1 misaligned, 2 bus, 3 illegal)
//   cop_mem_*              memory port (cen/wen/addr/wdata/ben out, rdata/stall/error in)
module scarv_cop_lsu #(
   parameter logic GATHER_EN = 1'b1
) (
   input  logic        g_clk,
   input  logic        g_reset,
   input  logic        lsu_req,
   output logic        lsu_req_ack,
   input  logic        lsu_store,
   input  logic [1:0]  lsu_size,
   input  logic        lsu_sg,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_offsets,
   input  logic [31:0] lsu_wdata,
   input  logic        lsu_abort,
   output logic        lsu_rsp_valid,
   input  logic        lsu_rsp_ack,
   output logic [31:0] lsu_rdata,
   output logic [2:0]  lsu_result,
   output logic        cop_mem_cen,
   output logic        cop_mem_wen,
   output logic [31:0] cop_mem_addr,
   output logic [31:0] cop_mem_wdata,
   input  logic [31:0] cop_mem_rdata,
   output logic [3:0]  cop_mem_ben,
   input  logic        cop_mem_stall,
   input  logic        cop_mem_error
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2} state_t;

   state_t      state_q, state_d;
   logic        store_q, store_d, sg_q, sg_d, abort_q, abort_d;
   logic [1:0]  size_q, size_d, beat_q, beat_d;
   logic [31:0] base_q, base_d, offs_q, offs_d, data_q, data_d;
   logic        rsp_valid_q, rsp_valid_d, cen_q, cen_d, wen_q, wen_d;
   logic [31:0] rdata_q, rdata_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [2:0]  result_q, result_d;
   logic [3:0]  ben_q, ben_d;

   logic        req_illegal_s, req_misaligned_s, abort_now_s, beat_done_s;
   logic [31:0] ba0_s, cur_ba_s;

   // Index of the final beat: 0 for plain accesses, 3 for sg bytes, 1 for sg halves.
   function automatic logic [1:0] last_beat(input logic sg, input logic [1:0] size);
      logic [1:0] r;
      if (!sg)                r = 2'd0;
      else if (size == 2'd0)  r = 2'd3;
      else                    r = 2'd1;
      return r;
   endfunction

   // Byte address of beat idx (base plus zero-extended offset, wrapping).
   function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [31:0] offs,
                                             input logic sg, input logic [1:0] size,
                                             input logic [1:0] idx);
      logic [31:0] off;
      if (!sg)               off = 32'd0;
      else if (size == 2'd0) off = {24'd0, offs[{idx, 3'b000} +: 8]};
      else                   off = {16'd0, offs[{idx[0], 4'b0000} +: 16]};
      return base + off;
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [31:0] a);
      logic r;
      case (size)
         2'd1:    r = a[0];
         2'd2:    r = (a[1:0] != 2'b00);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] beat_ben(input logic [1:0] size, input logic [31:0] a);
      logic [3:0] r;
      case (size)
         2'd0:    r = 4'b0001 << a[1:0];
         2'd1:    r = a[1] ? 4'b1100 : 4'b0011;
         default: r = 4'b1111;
      endcase
      return r;
   endfunction

   // Store lane replicated across the bus so it lands on whichever lane ben selects.
   function automatic logic [31:0] beat_wdata(input logic [1:0] size, input logic sg,
                                              input logic [31:0] data, input logic [1:0] idx);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = sg ? data[{idx, 3'b000} +: 8] : data[7:0];
      h = sg ? data[{idx[0], 4'b0000} +: 16] : data[15:0];
      case (size)
         2'd0:    r = {4{b}};
         2'd1:    r = {2{h}};
         default: r = data;
      endcase
      return r;
   endfunction

   // Selected lane of the read bus, zero-extended to bit 0.
   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] rd,
                                             input logic [31:0] a);
      logic [31:0] r;
      case (size)
         2'd0:    r = {24'd0, rd[{a[1:0], 3'b000} +: 8]};
         2'd1:    r = {16'd0, (a[1] ? rd[31:16] : rd[15:0])};
         default: r = rd;
      endcase
      return r;
   endfunction

   // Gathered beats land in their own byte/half slot; plain loads replace the result.
   function automatic logic [31:0] merge_load(input logic [31:0] acc, input logic sg,
                                              input logic [1:0] size, input logic [1:0] idx,
                                              input logic [31:0] lane);
      logic [31:0] r;
      r = acc;
      if (!sg)               r = lane;
      else if (size == 2'd0) r[{idx, 3'b000} +: 8] = lane[7:0];
      else                   r[{idx[0], 4'b0000} +: 16] = lane[15:0];
      return r;
   endfunction

   // Request classification: every beat address is checked before anything is issued.
   always_comb begin
      req_illegal_s    = (lsu_size == 2'd3) | (lsu_sg & (lsu_size == 2'd2)) | (lsu_sg & ~GATHER_EN);
      req_misaligned_s = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_misaligned_s = req_misaligned_s |
            ((2'(i) <= last_beat(lsu_sg, lsu_size)) &
             misaligned(lsu_size, beat_addr(lsu_addr, lsu_offsets, lsu_sg, lsu_size, 2'(i))));
      end
      ba0_s = beat_addr(lsu_addr, lsu_offsets, lsu_sg, lsu_size, 2'd0);
   end

   // Next-state and registered-output logic of the IDLE/ACCESS/RESP machine.
   always_comb begin
      state_d = state_q;   store_d = store_q;   sg_d = sg_q;         abort_d = abort_q;
      size_d = size_q;     beat_d = beat_q;     base_d = base_q;     offs_d = offs_q;
      data_d = data_q;     rsp_valid_d = rsp_valid_q;                rdata_d = rdata_q;
      result_d = result_q; cen_d = cen_q;       wen_d = wen_q;       ben_d = ben_q;
      mem_addr_d = mem_addr_q;                  mem_wdata_d = mem_wdata_q;

      cur_ba_s    = beat_addr(base_q, offs_q, sg_q, size_q, beat_q);
      abort_now_s = abort_q | lsu_abort;
      beat_done_s = cen_q & ~cop_mem_stall;

      case (state_q)
         ST_IDLE: begin
            if (lsu_req) begin
               store_d = lsu_store;  size_d = lsu_size;   sg_d = lsu_sg;
               base_d = lsu_addr;    offs_d = lsu_offsets; data_d = lsu_wdata;
               beat_d = 2'd0;        abort_d = 1'b0;      rdata_d = 32'd0;    result_d = 3'd0;
               if (req_illegal_s) begin
                  state_d = ST_RESP;  rsp_valid_d = 1'b1;  result_d = 3'd3;
               end else if (req_misaligned_s) begin
                  state_d = ST_RESP;  rsp_valid_d = 1'b1;  result_d = 3'd1;
               end else begin
                  // Beat 0 is issued straight from the request so it appears next cycle.
                  state_d     = ST_ACCESS;
                  cen_d       = 1'b1;
                  wen_d       = lsu_store;
                  mem_addr_d  = {ba0_s[31:2], 2'b00};
                  ben_d       = beat_ben(lsu_size, ba0_s);
                  mem_wdata_d = beat_wdata(lsu_size, lsu_sg, lsu_wdata, 2'd0);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (beat_done_s) begin
               cen_d = 1'b0;
               wen_d = 1'b0;
               if (abort_now_s) begin
                  state_d = ST_IDLE;  abort_d = 1'b0;
               end else if (cop_mem_error) begin
                  state_d = ST_RESP;  rsp_valid_d = 1'b1;  result_d = 3'd2;
               end else if (beat_q == last_beat(sg_q, size_q)) begin
                  rdata_d = merge_load(rdata_q, sg_q, size_q, beat_q, lane_data(size_q, cop_mem_rdata, cur_ba_s));
                  state_d = ST_RESP;  rsp_valid_d = 1'b1;  result_d = 3'd0;
               end else begin
                  rdata_d = merge_load(rdata_q, sg_q, size_q, beat_q, lane_data(size_q, cop_mem_rdata, cur_ba_s));
                  beat_d  = beat_q + 2'd1;
               end
            end else if (cen_q) begin
               // Stalled: everything on the bus holds; only remember an abort.
               abort_d = abort_now_s;
            end else if (abort_now_s) begin
               state_d = ST_IDLE;  abort_d = 1'b0;
            end else begin
               // Inter-beat gap cycle: issue the next beat.
               cen_d       = 1'b1;
               wen_d       = store_q;
               mem_addr_d  = {cur_ba_s[31:2], 2'b00};
               ben_d       = beat_ben(size_q, cur_ba_s);
               mem_wdata_d = beat_wdata(size_q, sg_q, data_q, beat_q);
            end
         end
         ST_RESP: begin
            if (lsu_rsp_ack | lsu_abort) begin
               state_d = ST_IDLE;  rsp_valid_d = 1'b0;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;  rsp_valid_d = 1'b0;  cen_d = 1'b0;  wen_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state_q <= ST_IDLE;  store_q <= 1'b0;  sg_q <= 1'b0;      abort_q <= 1'b0;
         size_q <= 2'd0;      beat_q <= 2'd0;   base_q <= 32'd0;   offs_q <= 32'd0;
         data_q <= 32'd0;     rsp_valid_q <= 1'b0;                 rdata_q <= 32'd0;
         result_q <= 3'd0;    cen_q <= 1'b0;    wen_q <= 1'b0;     ben_q <= 4'd0;
         mem_addr_q <= 32'd0; mem_wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;  store_q <= store_d;  sg_q <= sg_d;        abort_q <= abort_d;
         size_q <= size_d;    beat_q <= beat_d;    base_q <= base_d;    offs_q <= offs_d;
         data_q <= data_d;    rsp_valid_q <= rsp_valid_d;               rdata_q <= rdata_d;
         result_q <= result_d; cen_q <= cen_d;     wen_q <= wen_d;      ben_q <= ben_d;
         mem_addr_q <= mem_addr_d; mem_wdata_q <= mem_wdata_d;
      end
   end

   assign lsu_req_ack   = lsu_req & (state_q == ST_IDLE);
   assign lsu_rsp_valid = rsp_valid_q;
   assign lsu_rdata     = rdata_q;
   assign lsu_result    = result_q;
   assign cop_mem_cen   = cen_q;
   assign cop_mem_wen   = wen_q;
   assign cop_mem_addr  = mem_addr_q;
   assign cop_mem_wdata = mem_wdata_q;
   assign cop_mem_ben   = ben_q;

endmodule

// File: tb/tb_scarv_cop_lsu.sv
// Testbench for scarv_cop_lsu: directed cases plus randomized transactions,
// checked against a transaction-level model of the expected beats and response.
module tb_scarv_cop_lsu;

   logic        g_clk = 1'b0;
   logic        g_reset, lsu_req, lsu_req_ack, lsu_store, lsu_sg, lsu_abort;
   logic [1:0]  lsu_size;
   logic [31:0] lsu_addr, lsu_offsets, lsu_wdata, lsu_rdata;
   logic        lsu_rsp_valid, lsu_rsp_ack;
   logic [2:0]  lsu_result;
   logic        cop_mem_cen, cop_mem_wen, cop_mem_stall, cop_mem_error;
   logic [31:0] cop_mem_addr, cop_mem_wdata, cop_mem_rdata;
   logic [3:0]  cop_mem_ben;

   always #5 g_clk = ~g_clk;

   scarv_cop_lsu #(.GATHER_EN(1'b1)) dut (
      .g_clk(g_clk), .g_reset(g_reset), .lsu_req(lsu_req), .lsu_req_ack(lsu_req_ack),
      .lsu_store(lsu_store), .lsu_size(lsu_size), .lsu_sg(lsu_sg), .lsu_addr(lsu_addr),
      .lsu_offsets(lsu_offsets), .lsu_wdata(lsu_wdata), .lsu_abort(lsu_abort),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ack(lsu_rsp_ack), .lsu_rdata(lsu_rdata),
      .lsu_result(lsu_result), .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen),
      .cop_mem_addr(cop_mem_addr), .cop_mem_wdata(cop_mem_wdata), .cop_mem_rdata(cop_mem_rdata),
      .cop_mem_ben(cop_mem_ben), .cop_mem_stall(cop_mem_stall), .cop_mem_error(cop_mem_error)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  ben;
      logic        wen;
      logic [31:0] wdata;
   } beat_t;

   beat_t       exp_q[$];
   beat_t       m_beats[$];
   logic [2:0]  m_res;
   logic [31:0] m_rd;
   int          m_lat;
   int          plan_stall[4];
   int          plan_err;
   logic [31:0] mem [logic [31:0]];
   int          n_chk = 0;
   int          n_fail = 0;
   logic        mon_active = 1'b0;
   logic        rsp_exp = 1'b0;
   logic        exp_ld = 1'b0;
   logic [2:0]  exp_res = 3'd0;
   logic [31:0] exp_rd = 32'd0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E3779B1) ^ 32'h13579BDF;
   endfunction

   // Transaction-level model: list of beats, final status, load result, latency.
   function automatic void build_model(input logic st, input logic [1:0] sz, input logic sg,
                                       input logic [31:0] base, input logic [31:0] offs,
                                       input logic [31:0] wd);
      int          nb;
      logic [31:0] ba[4];
      logic        mis;
      logic [31:0] off, d, v;
      beat_t       b;
      m_beats.delete();
      m_rd = 32'd0;  m_lat = 0;  m_res = 3'd0;  mis = 1'b0;
      nb = !sg ? 1 : (sz == 2'd0 ? 4 : 2);
      for (int i = 0; i < nb; i++) begin
         off = !sg ? 32'd0 : (sz == 2'd0 ? ((offs >> (8 * i)) & 32'hFF) : ((offs >> (16 * i)) & 32'hFFFF));
         ba[i] = base + off;
         if (sz == 2'd1 && (ba[i] % 2) != 0) mis = 1'b1;
         if (sz == 2'd2 && (ba[i] % 4) != 0) mis = 1'b1;
      end
      if (sz == 2'd3 || (sg && sz == 2'd2)) begin m_res = 3'd3; return; end
      if (mis) begin m_res = 3'd1; return; end
      for (int i = 0; i < nb; i++) begin
         b.addr = ba[i] & ~32'h3;
         b.wen  = st;
         case (sz)
            2'd0: begin
               b.ben = 4'(1 << (ba[i] % 4));
               d = sg ? ((wd >> (8 * i)) & 32'hFF) : (wd & 32'hFF);
               b.wdata = d * 32'h01010101;
            end
            2'd1: begin
               b.ben = 4'(3 << (ba[i] % 4));
               d = sg ? ((wd >> (16 * i)) & 32'hFFFF) : (wd & 32'hFFFF);
               b.wdata = d * 32'h00010001;
            end
            default: begin
               b.ben = 4'hF;
               b.wdata = wd;
            end
         endcase
         m_beats.push_back(b);
         m_lat += 2 + plan_stall[i];
         if (plan_err == i) begin m_res = 3'd2; return; end
         v = mem_word(b.addr) >> (8 * (ba[i] % 4));
         v = v & (sz == 2'd0 ? 32'hFF : (sz == 2'd1 ? 32'hFFFF : 32'hFFFFFFFF));
         m_rd = m_rd | (sg ? (v << ((sz == 2'd0 ? 8 : 16) * i)) : v);
      end
   endfunction

   // Compare process: memory beats and response checked against the model each cycle.
   always @(negedge g_clk) begin
      if (mon_active) begin
         if (cop_mem_cen) begin
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_cen: got cen=1 addr=%h, expected no access", cop_mem_addr);
            end else begin
               chk("mem_addr", cop_mem_addr, exp_q[0].addr);
               chk("mem_ben", 32'(cop_mem_ben), 32'(exp_q[0].ben));
               chk("mem_wen", 32'(cop_mem_wen), 32'(exp_q[0].wen));
               if (exp_q[0].wen) chk("mem_wdata", cop_mem_wdata, exp_q[0].wdata);
               if (!cop_mem_stall) void'(exp_q.pop_front());
            end
         end
         if (lsu_rsp_valid) begin
            if (!rsp_exp) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 result=%0d, expected none", lsu_result);
            end else begin
               chk("rsp_result", 32'(lsu_result), 32'(exp_res));
               if (exp_res == 3'd0 && exp_ld) chk("rsp_rdata", lsu_rdata, exp_rd);
            end
         end
      end
   end

   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   task automatic drive_req(input logic st, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] offs, input logic [31:0] wd);
      lsu_req = 1'b1; lsu_store = st; lsu_size = sz; lsu_sg = sg;
      lsu_addr = a; lsu_offsets = offs; lsu_wdata = wd;
   endtask

   // After acceptance the request lines carry junk, so the DUT must use latched copies.
   task automatic scramble_req();
      lsu_req = 1'b0; lsu_store = 1'($urandom); lsu_size = 2'($urandom); lsu_sg = 1'($urandom);
      lsu_addr = $urandom; lsu_offsets = $urandom; lsu_wdata = $urandom;
   endtask

   task automatic run_txn(input logic st, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] offs, input logic [31:0] wd);
      int   cyc, beat, left, hold;
      logic got, done;
      build_model(st, sz, sg, a, offs, wd);
      foreach (m_beats[i]) exp_q.push_back(m_beats[i]);
      exp_res = m_res; exp_rd = m_rd; exp_ld = ~st; rsp_exp = 1'b1;
      drive_req(st, sz, sg, a, offs, wd);
      @(negedge g_clk);
      chk("req_ack", 32'(lsu_req_ack), 32'd1);
      step();
      scramble_req();
      cyc = 1; beat = 0; left = plan_stall[0]; got = 1'b0;
      while (!got && cyc < 400) begin
         if (lsu_rsp_valid) begin
            got = 1'b1;
         end else begin
            done = 1'b0;
            if (cop_mem_cen) begin
               cop_mem_rdata = mem_word(cop_mem_addr);
               if (left > 0) begin
                  cop_mem_stall = 1'b1; cop_mem_error = 1'($urandom_range(0, 1)); left--;
               end else begin
                  cop_mem_stall = 1'b0; cop_mem_error = (beat == plan_err); done = 1'b1;
               end
            end else begin
               cop_mem_stall = 1'b0; cop_mem_error = 1'b0; cop_mem_rdata = $urandom;
            end
            step();
            cyc++;
            if (done) begin
               beat++;
               left = (beat < 4) ? plan_stall[beat] : 0;
            end
         end
      end
      cop_mem_stall = 1'b0; cop_mem_error = 1'b0;
      if (!got) begin
         n_chk++; n_fail++;
         $display("FAIL rsp_timeout: got no rsp_valid in %0d cycles, expected one", cyc);
         rsp_exp = 1'b0;
      end else begin
         if (m_res == 3'd0 || m_res == 3'd2) chk("latency", 32'(cyc), 32'(m_lat));
         hold = $urandom_range(0, 2);
         repeat (hold) step();
         lsu_rsp_ack = 1'b1; lsu_req = 1'b1;
         @(negedge g_clk);
         chk("ack_cycle_req_ack", 32'(lsu_req_ack), 32'd0);
         step();
         lsu_rsp_ack = 1'b0; lsu_req = 1'b0; rsp_exp = 1'b0;
         chk("rsp_valid_after_ack", 32'(lsu_rsp_valid), 32'd0);
      end
      chk("beats_outstanding", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic clear_plan();
      for (int i = 0; i < 4; i++) plan_stall[i] = 0;
      plan_err = 99;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1);
   end

   initial begin
      logic        st, sg;
      logic [1:0]  sz;
      logic [31:0] a, offs;
      int          r;

      g_reset = 1'b1; lsu_req = 1'b0; lsu_store = 1'b0; lsu_size = 2'd0; lsu_sg = 1'b0;
      lsu_addr = 32'd0; lsu_offsets = 32'd0; lsu_wdata = 32'd0; lsu_abort = 1'b0;
      lsu_rsp_ack = 1'b0; cop_mem_rdata = 32'd0; cop_mem_stall = 1'b0; cop_mem_error = 1'b0;
      clear_plan();
      repeat (3) step();
      @(negedge g_clk);
      chk("reset_cen", 32'(cop_mem_cen), 32'd0);
      chk("reset_rsp_valid", 32'(lsu_rsp_valid), 32'd0);
      chk("reset_rdata", lsu_rdata, 32'd0);
      chk("reset_result", 32'(lsu_result), 32'd0);
      chk("reset_addr", cop_mem_addr, 32'd0);
      chk("reset_ben", 32'(cop_mem_ben), 32'd0);
      step();
      g_reset = 1'b0; mon_active = 1'b1;
      step();

      // Load word.
      mem[32'h1000] = 32'hDEADBEEF;
      build_model(1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, 32'd0);
      chk("pin_lw_rdata", m_rd, 32'hDEADBEEF);
      chk("pin_lw_ben", 32'(m_beats[0].ben), 32'hF);
      chk("pin_lw_lat", 32'(m_lat), 32'd2);
      run_txn(1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, 32'd0);

      // Store byte.
      build_model(1'b1, 2'd0, 1'b0, 32'h2003, 32'd0, 32'h000000A5);
      chk("pin_sb_addr", m_beats[0].addr, 32'h2000);
      chk("pin_sb_ben", 32'(m_beats[0].ben), 32'h8);
      chk("pin_sb_wdata", m_beats[0].wdata, 32'hA5A5A5A5);
      run_txn(1'b1, 2'd0, 1'b0, 32'h2003, 32'd0, 32'h000000A5);

      // Misaligned half and word: no access, result 1.
      build_model(1'b0, 2'd1, 1'b0, 32'h3001, 32'd0, 32'd0);
      chk("pin_mis_res", 32'(m_res), 32'd1);
      run_txn(1'b0, 2'd1, 1'b0, 32'h3001, 32'd0, 32'd0);
      run_txn(1'b0, 2'd2, 1'b0, 32'h3002, 32'd0, 32'd0);

      // Gather bytes.
      mem[32'h4000] = 32'h11; mem[32'h4004] = 32'h22; mem[32'h4008] = 32'h33; mem[32'h400C] = 32'h44;
      build_model(1'b0, 2'd0, 1'b1, 32'h4000, 32'h0C080400, 32'd0);
      chk("pin_gather_rdata", m_rd, 32'h44332211);
      chk("pin_gather_addr3", m_beats[3].addr, 32'h400C);
      chk("pin_gather_lat", 32'(m_lat), 32'd8);
      run_txn(1'b0, 2'd0, 1'b1, 32'h4000, 32'h0C080400, 32'd0);

      // Bus error on stalled gather beat 1.
      plan_stall[1] = 3; plan_err = 1;
      build_model(1'b0, 2'd0, 1'b1, 32'h4000, 32'h0C080400, 32'd0);
      chk("pin_err_res", 32'(m_res), 32'd2);
      chk("pin_err_beats", 32'(m_beats.size()), 32'd2);
      run_txn(1'b0, 2'd0, 1'b1, 32'h4000, 32'h0C080400, 32'd0);
      clear_plan();

      // Abort during stalled beat 0 of a scatter: beat completes, no response.
      build_model(1'b1, 2'd0, 1'b1, 32'h5000, 32'h03020100, 32'h44332211);
      chk("pin_abort_wdata", m_beats[0].wdata, 32'h11111111);
      exp_q.push_back(m_beats[0]); rsp_exp = 1'b0;
      drive_req(1'b1, 2'd0, 1'b1, 32'h5000, 32'h03020100, 32'h44332211);
      @(negedge g_clk);
      chk("abort_req_ack", 32'(lsu_req_ack), 32'd1);
      step();
      scramble_req();
      cop_mem_stall = 1'b1; lsu_abort = 1'b1;
      step();
      lsu_abort = 1'b0;
      step(); step();
      cop_mem_stall = 1'b0;
      step();
      repeat (4) begin
         @(negedge g_clk);
         chk("abort_cen_low", 32'(cop_mem_cen), 32'd0);
         chk("abort_no_rsp", 32'(lsu_rsp_valid), 32'd0);
         step();
      end
      chk("abort_beats_outstanding", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      run_txn(1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, 32'd0);

      // Abort while a response is pending.
      exp_res = 3'd1; exp_ld = 1'b1; rsp_exp = 1'b1;
      drive_req(1'b0, 2'd2, 1'b0, 32'h3002, 32'd0, 32'd0);
      step();
      scramble_req();
      r = 0;
      while (!lsu_rsp_valid && r < 10) begin step(); r++; end
      chk("rsp_abort_valid_seen", 32'(lsu_rsp_valid), 32'd1);
      lsu_abort = 1'b1;
      step();
      lsu_abort = 1'b0; rsp_exp = 1'b0;
      chk("rsp_abort_cleared", 32'(lsu_rsp_valid), 32'd0);

      // Reset in the middle of a stalled access.
      build_model(1'b0, 2'd2, 1'b0, 32'h6000, 32'd0, 32'd0);
      exp_q.push_back(m_beats[0]); rsp_exp = 1'b0;
      drive_req(1'b0, 2'd2, 1'b0, 32'h6000, 32'd0, 32'd0);
      step();
      scramble_req();
      cop_mem_stall = 1'b1;
      step(); step();
      g_reset = 1'b1;
      step();
      g_reset = 1'b0; cop_mem_stall = 1'b0;
      exp_q.delete();
      @(negedge g_clk);
      chk("rst_mid_cen", 32'(cop_mem_cen), 32'd0);
      chk("rst_mid_addr", cop_mem_addr, 32'd0);
      chk("rst_mid_ben", 32'(cop_mem_ben), 32'd0);
      chk("rst_mid_rsp", 32'(lsu_rsp_valid), 32'd0);
      step();

      // Randomized transactions.
      for (int n = 0; n < 150; n++) begin
         st = 1'($urandom);
         r  = $urandom_range(0, 15);
         sz = (r < 1) ? 2'd3 : (r < 6) ? 2'd0 : (r < 11) ? 2'd1 : 2'd2;
         sg = ($urandom_range(0, 2) == 0);
         a  = 32'h00010000 | ($urandom & 32'hFFF);
         if ($urandom_range(0, 9) == 0) a = 32'hFFFFFF00 | ($urandom & 32'hFF);
         offs = $urandom;
         if ($urandom_range(0, 9) < 7) begin
            a = a & ~32'h3;
            offs = offs & 32'hFFFEFFFE;
         end
         for (int i = 0; i < 4; i++) plan_stall[i] = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 3);
         plan_err = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 3) : 99;
         run_txn(st, sz, sg, a, offs, $urandom);
         if ($urandom_range(0, 1) == 1) step();
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
